// File: rtl/upload_rr_burst.sv
// upload_rr_burst: drains N_CH read FIFOs into one USB-FIFO transmit port, round-robin with bounded bursts.
// Optional feature: define UPLOAD_STATS_EN to add the 32-bit word_cnt output.
module upload_rr_burst #(
  parameter int DATA_W  = 8,
  parameter int N_CH    = 2,
  parameter int BURST   = 16,
  parameter int RD_LAT  = 1,
  parameter int WR_CYC  = 2,
  parameter int GAP_CYC = 3,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          fifo_empty,
  input  logic [N_CH*DATA_W-1:0]   fifo_dout,
  output logic [N_CH-1:0]          fifo_rd_en,
  input  logic                     txe_n,
  output logic [DATA_W-1:0]        ft_data,
  output logic                     ft_valid,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     busy
`ifdef UPLOAD_STATS_EN
  ,
  output logic [31:0]              word_cnt
`endif
);

  localparam int BCNT_W  = $clog2(BURST + 1);
  localparam int CNT_MAX = (RD_LAT > WR_CYC) ? ((RD_LAT > GAP_CYC) ? RD_LAT : GAP_CYC)
                                             : ((WR_CYC > GAP_CYC) ? WR_CYC : GAP_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_STB  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t              state_r;
  logic [N_CH-1:0]     rd_en_r;
  logic [DATA_W-1:0]   ft_data_r;
  logic                ft_valid_r;
  logic [CH_W-1:0]     cur_ch_r;
  logic                busy_r;
  logic [CH_W-1:0]     rr_ptr_r;
  logic [BCNT_W-1:0]   burst_cnt_r;
  logic [BCNT_W-1:0]   burst_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                txe_meta_r;
  logic                txe_sync_r;
  logic                txe_prev_r;
  logic                tx_ok_s;
  logic                grant_vld_s;
  logic [CH_W-1:0]     grant_ch_s;
  logic [DATA_W-1:0]   dout_arr_s [N_CH];
`ifdef UPLOAD_STATS_EN
  logic [31:0]         word_cnt_r;
  assign word_cnt = word_cnt_r;
`endif

  function automatic logic [CH_W-1:0] wrap_ch(input int v);
    return CH_W'(v % N_CH);
  endfunction

  function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [N_CH-1:0] v;
    v     = {N_CH{1'b0}};
    v[ch] = 1'b1;
    return v;
  endfunction

  for (genvar k = 0; k < N_CH; k++) begin : g_dout
    assign dout_arr_s[k] = fifo_dout[k*DATA_W +: DATA_W];
  end

  assign tx_ok_s     = ~txe_sync_r & ~txe_prev_r;
  assign burst_nxt_s = burst_cnt_r + BCNT_W'(1);

  assign fifo_rd_en = rd_en_r;
  assign ft_data    = ft_data_r;
  assign ft_valid   = ft_valid_r;
  assign cur_ch     = cur_ch_r;
  assign busy       = busy_r;

  // Two-flop synchroniser for txe_n plus a history flop so space must be seen on two cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      txe_meta_r <= 1'b1;
      txe_sync_r <= 1'b1;
      txe_prev_r <= 1'b1;
    end else begin
      txe_meta_r <= txe_n;
      txe_sync_r <= txe_meta_r;
      txe_prev_r <= txe_sync_r;
    end
  end

  // Round-robin scan from rr_ptr+1; descending loop so the nearest candidate wins
  always_comb begin
    grant_vld_s = 1'b0;
    grant_ch_s  = {CH_W{1'b0}};
    for (int i = N_CH; i >= 1; i--) begin
      grant_vld_s = grant_vld_s | ~fifo_empty[wrap_ch(int'(rr_ptr_r) + i)];
      grant_ch_s  = fifo_empty[wrap_ch(int'(rr_ptr_r) + i)] ? grant_ch_s
                                                             : wrap_ch(int'(rr_ptr_r) + i);
    end
  end

  // Upload FSM with registered strobes, data and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      rd_en_r     <= {N_CH{1'b0}};
      ft_data_r   <= {DATA_W{1'b0}};
      ft_valid_r  <= 1'b0;
      cur_ch_r    <= {CH_W{1'b0}};
      busy_r      <= 1'b0;
      rr_ptr_r    <= CH_W'(N_CH - 1);
      burst_cnt_r <= {BCNT_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
`ifdef UPLOAD_STATS_EN
      word_cnt_r  <= 32'd0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (tx_ok_s && grant_vld_s) begin
            state_r     <= S_RD;
            cur_ch_r    <= grant_ch_s;
            burst_cnt_r <= {BCNT_W{1'b0}};
            rd_en_r     <= ch_onehot(grant_ch_s);
            busy_r      <= 1'b1;
          end else begin
            rd_en_r     <= {N_CH{1'b0}};
            busy_r      <= 1'b0;
          end
        end
        S_RD: begin
          rd_en_r <= {N_CH{1'b0}};
          cnt_r   <= CNT_W'(RD_LAT - 1);
          state_r <= S_WT;
        end
        S_WT: begin
          if (cnt_r == CNT_W'(0)) begin
            ft_data_r  <= dout_arr_s[cur_ch_r];
            ft_valid_r <= 1'b1;
            cnt_r      <= CNT_W'(WR_CYC - 1);
            state_r    <= S_STB;
`ifdef UPLOAD_STATS_EN
            word_cnt_r <= word_cnt_r + 32'd1;
`endif
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        S_STB: begin
          if (cnt_r == CNT_W'(0)) begin
            ft_valid_r <= 1'b0;
            cnt_r      <= CNT_W'(GAP_CYC - 1);
            state_r    <= S_GAP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_r == CNT_W'(0)) begin
            burst_cnt_r <= burst_nxt_s;
            // Stay on the channel only while budget, data and space all remain
            if ((burst_nxt_s < BCNT_W'(BURST)) && !fifo_empty[cur_ch_r] && tx_ok_s) begin
              rd_en_r <= ch_onehot(cur_ch_r);
              state_r <= S_RD;
            end else begin
              rr_ptr_r <= cur_ch_r;
              busy_r   <= 1'b0;
              state_r  <= S_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r    <= S_IDLE;
          rd_en_r    <= {N_CH{1'b0}};
          ft_valid_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upload_rr_burst.sv
// Directed bench for upload_rr_burst: behavioural source FIFOs, a word scoreboard and timing checks.
module tb_upload_rr_burst;

  localparam int DATA_W  = 8;
  localparam int N_CH    = 2;
  localparam int BURST   = 16;
  localparam int RD_LAT  = 1;
  localparam int WR_CYC  = 2;
  localparam int GAP_CYC = 3;
  localparam int PERIOD  = 1 + RD_LAT + WR_CYC + GAP_CYC;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   txe_n;
  logic [N_CH-1:0]        fifo_empty = '1;
  logic [N_CH*DATA_W-1:0] fifo_dout  = '0;
  logic [N_CH-1:0]        fifo_rd_en;
  logic [DATA_W-1:0]      ft_data;
  logic                   ft_valid;
  logic [0:0]             cur_ch;
  logic                   busy;
`ifdef UPLOAD_STATS_EN
  logic [31:0]            word_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int n_rise      = 0;
  int rd_cnt0     = 0;
  int rd_cnt1     = 0;
  int last_rd_cyc = 0;
  int pulse_len   = 0;
  bit prev_valid  = 1'b0;
  bit stable_ok   = 1'b1;
  logic [DATA_W-1:0] hold_data = '0;

  logic [DATA_W-1:0] q0 [$];
  logic [DATA_W-1:0] q1 [$];
  logic [DATA_W:0]   exp_q [$];
  int                rise_q [$];

  upload_rr_burst #(
    .DATA_W(DATA_W), .N_CH(N_CH), .BURST(BURST),
    .RD_LAT(RD_LAT), .WR_CYC(WR_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .txe_n(txe_n), .ft_data(ft_data), .ft_valid(ft_valid),
    .cur_ch(cur_ch), .busy(busy)
`ifdef UPLOAD_STATS_EN
    , .word_cnt(word_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_push(input int ch, input logic [DATA_W-1:0] d);
    if (ch == 0) q0.push_back(d);
    else q1.push_back(d);
  endtask

  task automatic exp_push(input int ch, input logic [DATA_W-1:0] d);
    exp_q.push_back({ch[0], d});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !busy && !ft_valid)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(n < budget), 32'd1);
  endtask

  // Source FIFOs: pop on each observed rd_en pulse and refresh flags
  always @(negedge clk) begin
    if (fifo_rd_en != '0) begin
      check("rd_en_onehot", 32'($countones(fifo_rd_en)), 32'd1);
      last_rd_cyc = cyc;
    end
    if (fifo_rd_en[0]) begin
      rd_cnt0++;
      check("rd_en0_has_data", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) fifo_dout[DATA_W-1:0] = q0.pop_front();
    end
    if (fifo_rd_en[1]) begin
      rd_cnt1++;
      check("rd_en1_has_data", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) fifo_dout[2*DATA_W-1:DATA_W] = q1.pop_front();
    end
    fifo_empty = {(q1.size() == 0), (q0.size() == 0)};
  end

  // Output monitor: scoreboard on each strobe rise, width and stability on the fall
  always @(negedge clk) begin
    if (ft_valid && !prev_valid) begin
      n_rise++;
      rise_q.push_back(cyc);
      check("rd_to_valid", 32'(cyc - last_rd_cyc), 32'(1 + RD_LAT));
      if (exp_q.size() == 0) begin
        check("spurious_word", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        check("ft_data", 32'(ft_data), 32'(e[DATA_W-1:0]));
        check("grant_ch", 32'(cur_ch), 32'(e[DATA_W]));
      end
      hold_data = ft_data;
      pulse_len = 1;
      stable_ok = 1'b1;
    end else if (ft_valid) begin
      pulse_len++;
      if (ft_data !== hold_data) stable_ok = 1'b0;
    end else if (prev_valid) begin
      check("strobe_width", 32'(pulse_len), 32'(WR_CYC));
      check("data_stable", 32'(stable_ok), 32'd1);
    end
    prev_valid = ft_valid;
  end

  initial begin
    int n;
    int base;
    int b0;
    int b1;

    // Reset values
    rst   = 1'b1;
    txe_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_ft_valid", 32'(ft_valid), 32'd0);
    check("rst_ft_data", 32'(ft_data), 32'd0);
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst   = 1'b0;
    txe_n = 1'b0;

    // Single channel, three words, fixed period
    rise_q.delete();
    fifo_push(0, 8'hA1); fifo_push(0, 8'hA2); fifo_push(0, 8'hA3);
    exp_push(0, 8'hA1);  exp_push(0, 8'hA2);  exp_push(0, 8'hA3);
    wait_drain("t1", 200);
    check("t1_words", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() == 3) begin
      check("t1_period_a", 32'(rise_q[1] - rise_q[0]), 32'(PERIOD));
      check("t1_period_b", 32'(rise_q[2] - rise_q[1]), 32'(PERIOD));
    end
    check("t1_busy_low", 32'(busy), 32'd0);

    // Two full channels, bursts of BURST alternating from ch0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      fifo_push(0, 8'(i));
      fifo_push(1, 8'(8'h80 + i));
    end
    for (int blk = 0; blk < 3; blk++) begin
      for (int j = 0; j < ((blk < 2) ? 16 : 8); j++) exp_push(0, 8'(blk * 16 + j));
      for (int j = 0; j < ((blk < 2) ? 16 : 8); j++) exp_push(1, 8'(8'h80 + blk * 16 + j));
    end
    rise_q.delete();
    wait_drain("t2", 2000);
    check("t2_words", 32'(rise_q.size()), 32'd80);
    if (rise_q.size() == 80) begin
      check("t2_inburst_period", 32'(rise_q[1] - rise_q[0]), 32'(PERIOD));
      check("t2_regrant_period", 32'(rise_q[16] - rise_q[15]), 32'(PERIOD + 1));
    end

    // No space: nothing popped; release gives rd_en four edges later
    txe_n = 1'b1;
    repeat (4) @(negedge clk);
    b0 = rd_cnt0;
    for (int i = 0; i < 4; i++) begin
      fifo_push(0, 8'(8'hC0 + i));
      exp_push(0, 8'(8'hC0 + i));
    end
    repeat (20) @(negedge clk);
    check("t3_no_rd", 32'(rd_cnt0 - b0), 32'd0);
    check("t3_no_valid", 32'(ft_valid), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);
    txe_n = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (fifo_rd_en == '0 && n < 20);
    check("t3_release_latency", 32'(n), 32'd4);
    wait_drain("t3", 300);

    // Space lost during word 5 of a ch1 burst; re-grant goes to ch0
    for (int i = 0; i < 10; i++) begin
      fifo_push(0, 8'(8'h10 + i));
      fifo_push(1, 8'(8'h20 + i));
    end
    for (int i = 0; i < 5; i++)  exp_push(1, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) exp_push(0, 8'(8'h10 + i));
    for (int i = 5; i < 10; i++) exp_push(1, 8'(8'h20 + i));
    base = n_rise;
    b1   = rd_cnt1;
    n    = 0;
    while (n_rise < base + 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    txe_n = 1'b1;
    check("t4_reach_word5", 32'(n < 300), 32'd1);
    repeat (30) @(negedge clk);
    check("t4_rd_ch1", 32'(rd_cnt1 - b1), 32'd5);
    check("t4_burst_ended", 32'(busy), 32'd0);
    check("t4_words_out", 32'(n_rise - base), 32'd5);
    txe_n = 1'b0;
    wait_drain("t4", 800);

    // Reset while a popped ch1 word waits in WT; rr pointer must return to ch0 first
    fifo_push(0, 8'h33);
    exp_push(0, 8'h33);
    wait_drain("t5_pre", 200);
    fifo_push(1, 8'h5A);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!fifo_rd_en[1] && n < 50);
    check("t5_saw_rd", 32'(fifo_rd_en[1]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("t5_rst_ft_valid", 32'(ft_valid), 32'd0);
    check("t5_rst_ft_data", 32'(ft_data), 32'd0);
    check("t5_rst_cur_ch", 32'(cur_ch), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    fifo_push(0, 8'hE0);
    fifo_push(1, 8'hE1);
    exp_push(0, 8'hE0);
    exp_push(1, 8'hE1);
    wait_drain("t5", 300);

`ifdef UPLOAD_STATS_EN
    // Counter wraps from all-ones on the next word
    force dut.word_cnt_r = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.word_cnt_r;
    fifo_push(0, 8'h66);
    exp_push(0, 8'h66);
    wait_drain("t6", 200);
    check("t6_word_cnt_wrap", word_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
